// File: rtl/csea_level.sv
// One 8-bit carry-select adder level: two ripple chains precompute x+y+0 and
// x+y+1, previous_c_out picks one, and the result is registered. Optional
// registered signed overflow output is enabled by CSEA_LEVEL_OVF_EN.
module csea_level (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       previous_c_out,
`ifdef CSEA_LEVEL_OVF_EN
  output logic       ovf,
`endif
  output logic [7:0] z,
  output logic       next_c_out
);

  logic [8:0] c0;
  logic [8:0] c1;
  logic [7:0] s0;
  logic [7:0] s1;
  logic [8:0] res;
  logic [8:0] sum_d;
  logic [8:0] sum_q;

  assign c0[0] = 1'b0;
  assign c1[0] = 1'b1;

  // Two independent ripple chains so the select carry never sits on the
  // carry path of this level.
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign s0[i]   = x[i] ^ y[i] ^ c0[i];
    assign c0[i+1] = (x[i] & y[i]) | (c0[i] & (x[i] ^ y[i]));
    assign s1[i]   = x[i] ^ y[i] ^ c1[i];
    assign c1[i+1] = (x[i] & y[i]) | (c1[i] & (x[i] ^ y[i]));
  end

  always_comb begin
    res = previous_c_out ? {c1[8], s1} : {c0[8], s0};
  end

  assign sum_d = res;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= 9'h000;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign z          = sum_q[7:0];
  assign next_c_out = sum_q[8];

`ifdef CSEA_LEVEL_OVF_EN
  logic ovf_d;
  logic ovf_q;

  always_comb begin
    ovf_d = (x[7] == y[7]) && (res[7] != x[7]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csea_level.sv
// Self-checking bench for csea_level: directed steps plus a random sweep,
// expected results queued at drive time and compared after the capturing edge.
module tb_csea_level;

  logic       clk;
  logic       rst;
  logic [7:0] x;
  logic [7:0] y;
  logic       previous_c_out;
  logic [7:0] z;
  logic       next_c_out;
`ifdef CSEA_LEVEL_OVF_EN
  logic       ovf;
`endif

  typedef struct {
    logic [8:0] sum;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  csea_level dut (
    .clk            (clk),
    .rst            (rst),
    .x              (x),
    .y              (y),
    .previous_c_out (previous_c_out),
`ifdef CSEA_LEVEL_OVF_EN
    .ovf            (ovf),
`endif
    .z              (z),
    .next_c_out     (next_c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sum"}, {next_c_out, z}, 9'h000);
`ifdef CSEA_LEVEL_OVF_EN
    check({tag, "_ovf"}, {8'h00, ovf}, 9'h000);
`endif
  endtask

  // Drive on the falling edge, queue the expectation, compare just after
  // the next rising edge.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c);
    exp_t e;
    logic [8:0] s;
    @(negedge clk);
    x = a;
    y = b;
    previous_c_out = c;
    s = {1'b0, a} + {1'b0, b} + {8'h00, c};
    e.sum = s;
    e.ovf = (a[7] == b[7]) && (s[7] != a[7]);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 9'h000, 9'h001);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, {next_c_out, z}, e.sum);
`ifdef CSEA_LEVEL_OVF_EN
      check({tag, "_ovf"}, {8'h00, ovf}, {8'h00, e.ovf});
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    x = 8'hFF;
    y = 8'hFF;
    previous_c_out = 1'b1;
    #1;
    check_zero("reset_immediate");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero("reset_hold");
    end
    @(negedge clk);
    rst = 1'b0;

    step("no_carry",   8'd20,  8'd30,  1'b0);
    step("select",     8'd100, 8'd27,  1'b1);
    step("max",        8'd255, 8'd255, 1'b1);
    step("wrap",       8'd255, 8'd1,   1'b0);
    step("cin_only0",  8'd0,   8'd255, 1'b0);
    step("cin_only1",  8'd0,   8'd255, 1'b1);
    step("neg_ovf",    8'h80,  8'h80,  1'b0);

    for (int i = 0; i < 50; i++) begin
      step("sweep", 8'($urandom_range(255)), 8'($urandom_range(255)),
           1'($urandom_range(1)));
      if (i == 25) begin
        // Asynchronous clear between edges, then release before the next edge.
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_clear");
        @(negedge clk);
        check_zero("async_clear_hold");
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
